// File: rtl/comparator_pkg.sv
// ============================================================================
// Module   : comparator_pkg
// Brief    : Shared state encoding for the iterative magnitude comparator.
// Revision : 1.0
// ============================================================================
`default_nettype none

package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } comparator_state_t;

endpackage : comparator_pkg

`default_nettype wire

// File: rtl/comparator_chunk.sv
// ============================================================================
// Module   : comparator_chunk
// Brief    : Combinational unsigned W-bit compare producing equal / less-than.
// Revision : 1.0
// ============================================================================
`default_nettype none

module comparator_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o,
  output logic         lt_o
);

  assign eq_o = (a_i == b_i);
  assign lt_o = (a_i < b_i);

endmodule : comparator_chunk

`default_nettype wire

// File: rtl/comparator_iter.sv
// ============================================================================
// Module   : comparator_iter
// Brief    : Multi-cycle MSB-first chunked magnitude comparator with early exit
//            and valid/ready handshakes on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module comparator_iter
  import comparator_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int W  = 8,
  localparam int C  = N / W,
  localparam int CW = $clog2(C + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          is_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          equals,
  output logic          less_than,
  output logic          greater_than,
  output logic [CW-1:0] cycles
);

  localparam int          IW        = (C > 1) ? $clog2(C) : 1;
  localparam logic [N-1:0] SIGN_MASK = N'(1) << (N - 1);

  if ((N % W) != 0 || W < 1 || W > N) begin : g_param_check
    $error("comparator_iter: N must be a multiple of W and 1 <= W <= N");
  end

  comparator_state_t state_q, state_d;
  logic [N-1:0]      a_q, a_d, b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [CW-1:0]     cyc_q, cyc_d;

  logic [W-1:0]      a_chunk [C];
  logic [W-1:0]      b_chunk [C];
  logic              chunk_eq, chunk_lt;

  // Chunk 0 is the most significant slice, so index order matches scan order.
  for (genvar i = 0; i < C; i++) begin : g_chunk
    assign a_chunk[i] = a_q[N-1-i*W -: W];
    assign b_chunk[i] = b_q[N-1-i*W -: W];
  end

  comparator_chunk #(.W(W)) u_chunk (
    .a_i  (a_chunk[idx_q]),
    .b_i  (b_chunk[idx_q]),
    .eq_o (chunk_eq),
    .lt_o (chunk_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Flipping the sign bit maps two's-complement order onto unsigned order.
          a_d     = a ^ (SIGN_MASK & {N{is_signed}});
          b_d     = b ^ (SIGN_MASK & {N{is_signed}});
          idx_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (!chunk_eq) begin
          eq_d    = 1'b0;
          lt_d    = chunk_lt;
          gt_d    = !chunk_lt;
          cyc_d   = CW'(idx_q) + CW'(1);
          state_d = S_DONE;
        end else if (idx_q == IW'(C - 1)) begin
          eq_d    = 1'b1;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          cyc_d   = CW'(C);
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  assign equals       = eq_q;
  assign less_than    = lt_q;
  assign greater_than = gt_q;
  assign cycles       = cyc_q;

endmodule : comparator_iter

`default_nettype wire

// File: tb/tb_comparator_iter.sv
// ============================================================================
// Module   : tb_comparator_iter
// Brief    : Self-checking bench for comparator_iter (N=32, W=8) with a
//            scoreboard of expected results and immediate assertions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_comparator_iter;

  typedef struct packed {
    logic       eq;
    logic       lt;
    logic       gt;
    logic [2:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic        equals;
  logic        less_than;
  logic        greater_than;
  logic [2:0]  cycles;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  comparator_iter #(.N(32), .W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .is_signed    (is_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .equals       (equals),
    .less_than    (less_than),
    .greater_than (greater_than),
    .cycles       (cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: native signed/unsigned compare; latency from first differing byte.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic ms);
    exp_t e;
    logic found;
    e.eq  = (ma == mb);
    e.lt  = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
    e.gt  = !e.eq && !e.lt;
    e.cyc = 3'd4;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && (ma[31-8*i -: 8] != mb[31-8*i -: 8])) begin
        e.cyc = 3'(i + 1);
        found = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic txn(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(ta, tb_v, ts));
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    is_signed = ts;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a         = $urandom;
    b         = $urandom;
    is_signed = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 40);
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.cyc));
    check("out_valid", 32'(out_valid), 32'd1);
    check("equals", 32'(equals), 32'(e.eq));
    check("less_than", 32'(less_than), 32'(e.lt));
    check("greater_than", 32'(greater_than), 32'(e.gt));
    check("cycles", 32'(cycles), 32'(e.cyc));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a        = ~ta;
      b        = tb_v + 32'd7;
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_result", {29'd0, equals, less_than, greater_than},
            {29'd0, e.eq, e.lt, e.gt});
      check("hold_cycles", 32'(cycles), 32'(e.cyc));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", {29'd0, equals, less_than, greater_than}, 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    rst = 1'b0;

    txn(32'h0000_0000, 32'h0000_0000, 1'b1, 0);
    txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
    txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    txn(32'h0000_9581, 32'h0000_9582, 1'b0, 0);
    txn(32'h0000_9581, 32'h0001_9581, 1'b0, 0);
    txn(32'h0000_9581, 32'h0000_9581, 1'b0, 0);
    txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
    txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);

    txn(32'h1234_5678, 32'h1234_0000, 1'b0, 5);

    // Reset mid-computation must discard the transaction.
    in_valid  = 1'b1;
    a         = 32'd1;
    b         = 32'd2;
    is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", {29'd0, equals, less_than, greater_than}, 32'd0);
    check("midrst_cycles", 32'(cycles), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("midrst_no_result", 32'(out_valid), 32'd0);
    end
    txn(32'd5, 32'd5, 1'b0, 0);

    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = ra;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 1) == 1) rb[8*c +: 8] = 8'($urandom);
      end
      txn(ra, rb, 1'($urandom), (i % 17 == 3) ? 2 : 0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_comparator_iter

`default_nettype wire

// File: doc/comparator_iter.md
Name: comparator_iter

Overview:
Multi-cycle, parametrised magnitude comparator producing equals / less_than / greater_than for two N-bit operands, signed or unsigned per transaction. Scans W-bit chunks MSB-first and terminates early at the first differing chunk, trading latency for area versus the single-cycle comparator_eq/comparator_lt. Sits between a producer and consumer with valid/ready handshakes on both sides, e.g. in front of branch-resolution or sort datapaths.

Parameters:
N, 32, operand width in bits; N % W == 0 required (elaboration-time $error otherwise)
W, 8, chunk width compared per cycle; 1 <= W <= N
(derived) C = N/W chunk count; CW = $clog2(C+1) width of cycles output

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands
a  in  N  operand A
b  in  N  operand B
is_signed  in  1  1 = two's-complement compare, 0 = unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
equals  out  1  a == b
less_than  out  1  a < b
greater_than  out  1  a > b
cycles  out  CW  chunks examined for this result (1..C)

Behaviour:
- Reset: one clock is synchronous and active-high; clk is the only clock, rst the reset. On rst: state=S_IDLE, out_valid=0, equals=less_than=greater_than=0, cycles=0, internal chunk index=0. rst overrides all other inputs in the same cycle.
- States: S_IDLE, S_BUSY, S_DONE.
- S_IDLE: in_ready=1. Accept when in_valid && in_ready at a posedge: latch a, b, is_signed into operand registers; if is_signed, invert bit N-1 of both latched operands (maps signed order onto unsigned order); idx=0; -> S_BUSY.
- S_BUSY: in_ready=0. Each cycle compare chunk idx (bits N-1-idx*W downto N-W-idx*W) of latched A vs B, unsigned.
  - chunks differ: register less_than/greater_than from chunk compare, equals=0, cycles=idx+1, -> S_DONE.
  - chunks equal and idx==C-1: equals=1, lt=gt=0, cycles=C, -> S_DONE.
  - otherwise idx++.
- Latency: out_valid rises k cycles after the accept edge, k = index of first differing chunk + 1 (k=C when equal). Throughput: at most one transaction per k+2 cycles.
- S_DONE: out_valid=1, in_ready=0; result outputs held stable. On out_valid && out_ready -> S_IDLE; out_valid drops next cycle. No same-cycle accept of new operands (in_ready only high in S_IDLE).
- Exactly one of equals/less_than/greater_than is 1 whenever out_valid=1. Outputs keep their last value after leaving S_DONE until next result; consumers must qualify with out_valid.
- in_valid asserted outside S_IDLE is ignored; a, b, is_signed sampled only on the accept edge (may change freely afterwards).
- rst asserted in S_BUSY or S_DONE: transaction discarded, no out_valid pulse, reset values next cycle.
- W==N degenerates to 1-cycle compare; W==1 gives bit-serial, up to N cycles.
- All outputs driven from registers or state decode only; no combinational path from inputs to outputs except none (in_ready is a state decode).

Decomposition:
- Package comparator_pkg: typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} comparator_state_t.
- Sub-module comparator_chunk #(.W): combinational unsigned W-bit compare, outputs eq and lt; one instance muxed by idx. Chunk select via indexed part-select on the latched operands.

Test Plan:
(N=32, W=8, C=4, out_ready=1 unless stated)
1. a=0, b=0, signed -> out_valid 4 cycles after accept; equals=1, lt=0, gt=0, cycles=4.
2. a=32'hFFFF_FFFF, b=1: signed -> less_than=1, cycles=1; unsigned -> greater_than=1, cycles=1.
3. a=38273 (32'h0000_9581) vs b=32'h0000_9582 -> less_than=1, cycles=4; vs b=32'h0001_9581 -> less_than=1, cycles=2; vs b=38273 -> equals=1, cycles=4.
4. a=32'h8000_0000, b=32'h7FFF_FFFF: signed -> less_than=1; unsigned -> greater_than=1; both cycles=1.
5. Backpressure: hold out_ready=0 for 5 cycles in S_DONE -> out_valid=1 and outputs stable throughout, in_ready=0, a concurrent in_valid with new operands ignored; out_ready=1 -> in_ready=1 next cycle.
6. Assert rst for one cycle during S_BUSY (a=1, b=2) -> next cycle in_ready=1, out_valid=0, outputs 0, no result emitted; following transaction a=5, b=5 yields equals=1, cycles=4. Plus 100 random signed/unsigned pairs checked against behavioural compare, cycles checked against first-differing-chunk model.
